// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// buffers returned words in a 2-entry queue handed to decode via valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] next_address,
    input  logic [31:0] redirect_pc,
    input  logic        beq,
    input  logic        zero,
    input  logic        jump,
    input  logic [15:0] branch_off,
    input  logic [25:0] jump_target
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] issue_pc_q, issue_pc_d;
    logic        inflight_q, inflight_d;
    logic        drop_q, drop_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];

    logic        take, pop, push, issue;
    logic [31:0] seq_pc, jump_tgt, branch_tgt, redirect_tgt;
    logic [2:0]  occupancy;

    always_comb begin
        take         = jump | (beq & zero);
        seq_pc       = redirect_pc + 32'd4;
        jump_tgt     = {seq_pc[31:28], jump_target, 2'b00};
        branch_tgt   = seq_pc + {{14{branch_off[15]}}, branch_off, 2'b00};
        redirect_tgt = jump ? jump_tgt : branch_tgt;

        inst_valid   = (count_q != 2'd0);
        pop          = inst_valid & inst_ready;
        push         = inflight_q & ~drop_q;
        // Slots already claimed (queued + in flight) after this cycle's pop.
        occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue        = ~rst & ~take & (occupancy < 3'd2);

        imem_en      = issue;
        imem_addr    = fetch_pc_q;
        instruction  = inst_valid ? fifo_instr_q[rd_ptr_q] : '0;
        pc           = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
        next_address = inst_valid ? fifo_pc_q[rd_ptr_q] + PC_STEP : '0;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = issue;
        drop_d     = take & issue;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        if (issue) begin
            issue_pc_d = fetch_pc_q;
        end
        if (take) begin
            // Redirect flushes the queue and ignores any same-cycle pop.
            fetch_pc_d = redirect_tgt;
            count_d    = '0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            issue_pc_q <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by inst_valid.
    always_ff @(posedge clk) begin
        if (!rst && !take && push) begin
            fifo_pc_q[wr_ptr_q]    <= issue_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset/streaming, backpressure, redirect
// vector table, PC wrap-around and reset in the middle of operation.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_ready;
    logic [31:0] redirect_pc;
    logic        beq, zero, jump;
    logic [15:0] branch_off;
    logic [25:0] jump_target;

    logic        en0, valid0, en1, valid1;
    logic [31:0] addr0, rdata0, instr0, pc0, na0;
    logic [31:0] addr1, rdata1, instr1, pc1, na1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut0 (
        .clk(clk), .rst(rst), .imem_en(en0), .imem_addr(addr0), .imem_rdata(rdata0),
        .inst_valid(valid0), .inst_ready(inst_ready), .instruction(instr0), .pc(pc0),
        .next_address(na0), .redirect_pc(redirect_pc), .beq(beq), .zero(zero),
        .jump(jump), .branch_off(branch_off), .jump_target(jump_target)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut1 (
        .clk(clk), .rst(rst), .imem_en(en1), .imem_addr(addr1), .imem_rdata(rdata1),
        .inst_valid(valid1), .inst_ready(inst_ready), .instruction(instr1), .pc(pc1),
        .next_address(na1), .redirect_pc(redirect_pc), .beq(beq), .zero(zero),
        .jump(jump), .branch_off(branch_off), .jump_target(jump_target)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    // Memory word k holds k; idle cycles return junk so a bogus push shows up.
    always @(posedge clk) begin
        rdata0 <= en0 ? word_at(addr0) : 32'hDEAD_BEEF;
        rdata1 <= en1 ? word_at(addr1) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dut0.inflight_q && !dut0.drop_q && dut0.count_q == 2'd2 &&
                      !(valid0 && inst_ready)))
            else begin
                bad++;
                $display("FAIL push_into_full: push with count=2 and no pop at %0t", $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic clear_ctrl();
        redirect_pc = '0;
        beq         = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        branch_off  = '0;
        jump_target = '0;
    endtask

    typedef struct {
        logic [31:0] rpc;
        logic        beq;
        logic        zero;
        logic        jump;
        logic [15:0] off;
        logic [25:0] jt;
        logic        take;
        logic [31:0] tgt;
    } vec_t;

    vec_t vecs [9];
    logic [31:0] exp_pc;

    initial begin
        vecs[0] = '{32'h0000_0020, 1'b1, 1'b1, 1'b0, 16'hFFFC, 26'h0,       1'b1, 32'h0000_0014};
        vecs[1] = '{32'h0000_0020, 1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0,       1'b0, 32'h0};
        vecs[2] = '{32'hF000_0010, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000100, 1'b1, 32'hF000_0400};
        vecs[3] = '{32'hF000_0010, 1'b1, 1'b1, 1'b1, 16'h0004, 26'h0000100, 1'b1, 32'hF000_0400};
        vecs[4] = '{32'hFFFF_FFF0, 1'b1, 1'b1, 1'b0, 16'h0010, 26'h0,       1'b1, 32'h0000_0034};
        vecs[5] = '{32'h0000_0000, 1'b1, 1'b1, 1'b0, 16'h8000, 26'h0,       1'b1, 32'hFFFE_0004};
        vecs[6] = '{32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h3FFFFFF, 1'b1, 32'h0FFF_FFFC};
        vecs[7] = '{32'h0000_0040, 1'b0, 1'b1, 1'b0, 16'h0008, 26'h0000010, 1'b0, 32'h0};
        vecs[8] = '{32'h1000_0000, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0000001, 1'b1, 32'h1000_0004};

        rst        = 1'b1;
        inst_ready = 1'b1;
        clear_ctrl();
        repeat (3) @(posedge clk);

        // Reset state
        @(negedge clk); #1;
        chk1("rst_valid", valid0, 1'b0);
        chk1("rst_imem_en", en0, 1'b0);
        chk("rst_instruction", instr0, 32'h0);
        chk("rst_pc", pc0, 32'h0);
        chk("rst_next_address", na0, 32'h0);

        // First fetch after release
        @(negedge clk); rst = 1'b0; #1;
        chk1("first_imem_en", en0, 1'b1);
        chk("first_imem_addr", addr0, 32'h0);
        chk("wrap_first_addr", addr1, 32'hFFFF_FFFC);
        chk1("first_valid_c0", valid0, 1'b0);
        @(negedge clk); #1;
        chk1("first_valid_c1", valid0, 1'b0);
        chk("second_imem_addr", addr0, 32'h4);
        chk("wrap_second_addr", addr1, 32'h0);
        @(negedge clk); #1;
        chk1("first_valid_c2", valid0, 1'b1);
        chk("first_pc", pc0, 32'h0);
        chk("first_instruction", instr0, 32'h0);
        chk("first_next_address", na0, 32'h4);
        chk("wrap_head_pc", pc1, 32'hFFFF_FFFC);
        chk("wrap_head_instr", instr1, 32'h3FFF_FFFF);
        chk("wrap_head_next", na1, 32'h0);
        exp_pc = 32'h0;

        // Sustained streaming, one instruction per cycle
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            exp_pc = exp_pc + 32'd4;
            chk1("stream_valid", valid0, 1'b1);
            chk("stream_pc", pc0, exp_pc);
            chk("stream_instr", instr0, word_at(exp_pc));
            chk("stream_next", na0, exp_pc + 32'd4);
            chk("stream_addr", addr0, exp_pc + 32'd8);
            if (i == 0) chk("wrap_second_pc", pc1, 32'h0);
        end

        // Backpressure: head held, issue stops
        exp_pc = exp_pc + 32'd4;
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk); inst_ready = 1'b0; #1;
            chk1("bp_valid", valid0, 1'b1);
            chk("bp_pc_held", pc0, exp_pc);
            chk("bp_instr_held", instr0, word_at(exp_pc));
            chk1("bp_imem_en", en0, 1'b0);
        end
        @(negedge clk); inst_ready = 1'b1; #1;
        chk1("bp_release_en", en0, 1'b1);
        chk("bp_release_addr", addr0, exp_pc + 32'd8);
        chk("bp_release_pc", pc0, exp_pc);
        for (int unsigned i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            exp_pc = exp_pc + 32'd4;
            chk1("bp_drain_valid", valid0, 1'b1);
            chk("bp_drain_pc", pc0, exp_pc);
            chk("bp_drain_instr", instr0, word_at(exp_pc));
            chk("bp_drain_addr", addr0, exp_pc + 32'd8);
        end

        // Redirect vectors
        for (int unsigned v = 0; v < 9; v++) begin
            @(negedge clk);
            redirect_pc = vecs[v].rpc;
            beq         = vecs[v].beq;
            zero        = vecs[v].zero;
            jump        = vecs[v].jump;
            branch_off  = vecs[v].off;
            jump_target = vecs[v].jt;
            #1;
            exp_pc = exp_pc + 32'd4;
            chk1("rd_issue_blocked", en0, ~vecs[v].take);
            chk("rd_pc_before", pc0, exp_pc);
            @(negedge clk); clear_ctrl(); #1;
            if (vecs[v].take) begin
                chk1("rd_flush_valid", valid0, 1'b0);
                chk1("rd_target_en", en0, 1'b1);
                chk("rd_target_addr", addr0, vecs[v].tgt);
                @(negedge clk); #1;
                chk1("rd_gap_valid", valid0, 1'b0);
                chk("rd_gap_addr", addr0, vecs[v].tgt + 32'd4);
                @(negedge clk); #1;
                chk1("rd_arrive_valid", valid0, 1'b1);
                chk("rd_arrive_pc", pc0, vecs[v].tgt);
                chk("rd_arrive_instr", instr0, word_at(vecs[v].tgt));
                chk("rd_arrive_next", na0, vecs[v].tgt + 32'd4);
                exp_pc = vecs[v].tgt;
            end else begin
                exp_pc = exp_pc + 32'd4;
                chk1("nr_valid", valid0, 1'b1);
                chk("nr_pc", pc0, exp_pc);
                chk("nr_addr", addr0, exp_pc + 32'd8);
            end
        end

        // Reset mid-operation: fill queue, then reset with a response in flight
        repeat (3) begin
            @(negedge clk); inst_ready = 1'b0;
        end
        @(negedge clk); inst_ready = 1'b1; #1;
        chk1("mr_refill_en", en0, 1'b1);
        @(negedge clk); rst = 1'b1; inst_ready = 1'b0; #1;
        chk1("mr_rst_en", en0, 1'b0);
        @(negedge clk); rst = 1'b0; inst_ready = 1'b1; #1;
        chk1("mr_valid", valid0, 1'b0);
        chk("mr_instruction", instr0, 32'h0);
        chk("mr_pc", pc0, 32'h0);
        chk("mr_next_address", na0, 32'h0);
        chk1("mr_restart_en", en0, 1'b1);
        chk("mr_restart_addr", addr0, 32'h0);
        @(negedge clk); #1;
        chk1("mr_stale_dropped", valid0, 1'b0);
        chk("mr_second_addr", addr0, 32'h4);
        @(negedge clk); #1;
        chk1("mr_first_valid", valid0, 1'b1);
        chk("mr_first_pc", pc0, 32'h0);
        chk("mr_first_instr", instr0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
